// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding and
// default widths/step used by the PC and instruction paths.
package fetch_ctrl_pkg;

   localparam int unsigned ADDR_W_DFLT = 32;
   localparam int unsigned DATA_W_DFLT = 32;
   localparam int unsigned STEP_DFLT   = 4;

   typedef enum logic [1:0] {
      StStart,
      StFetch,
      StHold,
      StDiscard
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC register, runs the imem req/ack
// handshake, fills the IF/ID register and handles stalls and branch redirects.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DFLT,
   parameter int unsigned DATA_W = DATA_W_DFLT,
   parameter int unsigned STEP   = STEP_DFLT,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_next,
   output logic              pc_freeze,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_instr,
   output logic [CNT_W-1:0]  fetched_count
);

   fetch_state_e      state_q, state_d;
   logic              if_valid_q, if_valid_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;
   logic [DATA_W-1:0] if_instr_q, if_instr_d;
   logic [DATA_W-1:0] pend_instr_q, pend_instr_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic [ADDR_W-1:0] redir_addr_q, redir_addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cnt_inc;
   logic [ADDR_W-1:0] pc_seq;

   // Sequential successor wraps silently at the top of the address space.
   assign pc_seq    = pc + ADDR_W'(STEP);
   assign imem_addr = pc;

   always_comb begin
      state_d      = state_q;
      if_valid_d   = if_valid_q;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;
      pend_instr_d = pend_instr_q;
      pend_pc_d    = pend_pc_q;
      redir_addr_d = redir_addr_q;
      cnt_inc      = 1'b0;
      imem_req     = 1'b0;
      pc_freeze    = 1'b1;
      pc_next      = pc;

      unique case (state_q)
         StStart: begin
            state_d = StFetch;
         end
         StFetch: begin
            imem_req = 1'b1;
            if (branch_taken && imem_ack) begin
               pc_next    = branch_addr;
               pc_freeze  = 1'b0;
               if_valid_d = 1'b0;
            end else if (branch_taken) begin
               redir_addr_d = branch_addr;
               if_valid_d   = 1'b0;
               state_d      = StDiscard;
            end else if (imem_ack && freeze) begin
               pend_instr_d = imem_rdata;
               pend_pc_d    = pc;
               state_d      = StHold;
            end else if (imem_ack) begin
               if_instr_d = imem_rdata;
               if_pc_d    = pc;
               if_valid_d = 1'b1;
               pc_next    = pc_seq;
               pc_freeze  = 1'b0;
               cnt_inc    = 1'b1;
            end else if (!freeze) begin
               if_valid_d = 1'b0;
            end
         end
         StHold: begin
            if (branch_taken) begin
               pc_next    = branch_addr;
               pc_freeze  = 1'b0;
               if_valid_d = 1'b0;
               state_d    = StFetch;
            end else if (!freeze) begin
               if_instr_d = pend_instr_q;
               if_pc_d    = pend_pc_q;
               if_valid_d = 1'b1;
               pc_next    = pc_seq;
               pc_freeze  = 1'b0;
               cnt_inc    = 1'b1;
               state_d    = StFetch;
            end
         end
         StDiscard: begin
            // Wait out the stale response; the newest redirect target wins.
            imem_req   = 1'b1;
            if_valid_d = 1'b0;
            if (branch_taken) begin
               redir_addr_d = branch_addr;
            end
            if (imem_ack) begin
               pc_next   = branch_taken ? branch_addr : redir_addr_q;
               pc_freeze = 1'b0;
               state_d   = StFetch;
            end
         end
         default: begin
            state_d = StStart;
         end
      endcase

      cnt_d = cnt_q;
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StStart;
         if_valid_q   <= 1'b0;
         if_pc_q      <= '0;
         if_instr_q   <= '0;
         pend_instr_q <= '0;
         pend_pc_q    <= '0;
         redir_addr_q <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         if_valid_q   <= if_valid_d;
         if_pc_q      <= if_pc_d;
         if_instr_q   <= if_instr_d;
         pend_instr_q <= pend_instr_d;
         pend_pc_q    <= pend_pc_d;
         redir_addr_q <= redir_addr_d;
         cnt_q        <= cnt_d;
      end
   end

   assign if_valid      = if_valid_q;
   assign if_pc         = if_pc_q;
   assign if_instr      = if_instr_q;
   assign fetched_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a simple PC-register model driven by
// pc_freeze/pc_next, plus a load path to place the PC at chosen addresses.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        pc_freeze;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [31:0] fetched_count;

   logic        pc_load;
   logic [31:0] pc_load_val;

   int n_checks = 0;
   int n_errors = 0;

   fetch_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .pc            (pc),
      .pc_next       (pc_next),
      .pc_freeze     (pc_freeze),
      .freeze        (freeze),
      .branch_taken  (branch_taken),
      .branch_addr   (branch_addr),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .fetched_count (fetched_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pc_load) pc <= pc_load_val;
      else if (!pc_freeze) pc <= pc_next;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      pc = 32'h0; reset = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
      branch_addr = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
      pc_load = 1'b0; pc_load_val = 32'h0;

      // Reset
      tick(); tick();
      chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_count", fetched_count, 32'h0);
      reset = 1'b1;
      #1;
      chk("start_req", {31'b0, imem_req}, 32'h0);
      chk("start_freeze", {31'b0, pc_freeze}, 32'h1);
      tick();

      // Zero-wait memory: one instruction per cycle
      imem_ack = 1'b1; imem_rdata = 32'h11;
      #1;
      chk("zw_req", {31'b0, imem_req}, 32'h1);
      chk("zw_addr0", imem_addr, 32'h0);
      chk("zw_pc_next0", pc_next, 32'h4);
      chk("zw_pc_freeze0", {31'b0, pc_freeze}, 32'h0);
      tick();
      chk("zw_if_pc0", if_pc, 32'h0);
      chk("zw_if_instr0", if_instr, 32'h11);
      chk("zw_if_valid0", {31'b0, if_valid}, 32'h1);
      imem_rdata = 32'h22;
      #1;
      chk("zw_addr1", imem_addr, 32'h4);
      tick();
      chk("zw_if_pc1", if_pc, 32'h4);
      chk("zw_if_instr1", if_instr, 32'h22);
      imem_rdata = 32'h33;
      tick();
      chk("zw_if_pc2", if_pc, 32'h8);
      chk("zw_if_instr2", if_instr, 32'h33);
      chk("zw_count", fetched_count, 32'h3);

      // Ack delayed three cycles at 0x10
      imem_ack = 1'b0; pc_load = 1'b1; pc_load_val = 32'h10;
      tick();
      pc_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("dly_addr", imem_addr, 32'h10);
         chk("dly_pc_freeze", {31'b0, pc_freeze}, 32'h1);
         tick();
         chk("dly_if_valid", {31'b0, if_valid}, 32'h0);
      end
      imem_ack = 1'b1; imem_rdata = 32'h55;
      #1;
      chk("dly_pc_next", pc_next, 32'h14);
      chk("dly_pc_freeze_ack", {31'b0, pc_freeze}, 32'h0);
      tick();
      chk("dly_if_pc", if_pc, 32'h10);
      chk("dly_if_instr", if_instr, 32'h55);
      chk("dly_count", fetched_count, 32'h4);

      // Stall across the ack at 0x20
      imem_ack = 1'b0; freeze = 1'b1; pc_load = 1'b1; pc_load_val = 32'h20;
      tick();
      pc_load = 1'b0;
      chk("stall_if_hold_valid", {31'b0, if_valid}, 32'h1);
      chk("stall_if_hold_pc", if_pc, 32'h10);
      imem_ack = 1'b1; imem_rdata = 32'h66;
      #1;
      chk("stall_pc_freeze", {31'b0, pc_freeze}, 32'h1);
      tick();
      imem_ack = 1'b0;
      #1;
      chk("hold_req0", {31'b0, imem_req}, 32'h0);
      chk("hold_if_pc0", if_pc, 32'h10);
      tick();
      imem_ack = 1'b1; imem_rdata = 32'h77;  // ignored: no request in HOLD
      #1;
      chk("hold_req1", {31'b0, imem_req}, 32'h0);
      chk("hold_if_instr1", if_instr, 32'h55);
      tick();
      imem_ack = 1'b0; freeze = 1'b0;
      #1;
      chk("hold_rel_pc_next", pc_next, 32'h24);
      chk("hold_rel_pc_freeze", {31'b0, pc_freeze}, 32'h0);
      tick();
      chk("hold_rel_if_pc", if_pc, 32'h20);
      chk("hold_rel_if_instr", if_instr, 32'h66);
      chk("hold_rel_count", fetched_count, 32'h5);
      chk("hold_rel_addr", imem_addr, 32'h24);
      chk("hold_rel_req", {31'b0, imem_req}, 32'h1);

      // Branch while a request at 0x40 is outstanding
      pc_load = 1'b1; pc_load_val = 32'h40;
      tick();
      pc_load = 1'b0;
      tick();
      branch_taken = 1'b1; branch_addr = 32'h100;
      tick();
      branch_taken = 1'b0;
      #1;
      chk("disc_if_valid", {31'b0, if_valid}, 32'h0);
      chk("disc_req", {31'b0, imem_req}, 32'h1);
      chk("disc_addr", imem_addr, 32'h40);
      chk("disc_pc_freeze", {31'b0, pc_freeze}, 32'h1);
      tick();
      imem_ack = 1'b1; imem_rdata = 32'hDEAD;
      #1;
      chk("disc_pc_next", pc_next, 32'h100);
      tick();
      imem_ack = 1'b0;
      #1;
      chk("disc_if_instr", if_instr, 32'h66);
      chk("disc_if_valid_after", {31'b0, if_valid}, 32'h0);
      chk("disc_new_addr", imem_addr, 32'h100);
      chk("disc_count", fetched_count, 32'h5);

      // Second branch in DISCARD coincides with the stale ack
      branch_taken = 1'b1; branch_addr = 32'h180;
      tick();
      branch_addr = 32'h200; imem_ack = 1'b1; imem_rdata = 32'hBEEF;
      #1;
      chk("redir2_pc_next", pc_next, 32'h200);
      tick();
      branch_taken = 1'b0; imem_ack = 1'b0;
      #1;
      chk("redir2_addr", imem_addr, 32'h200);
      chk("redir2_if_instr", if_instr, 32'h66);

      // Branch and freeze together: flush wins
      imem_ack = 1'b1; imem_rdata = 32'h77;
      tick();
      chk("pre_flush_valid", {31'b0, if_valid}, 32'h1);
      chk("pre_flush_count", fetched_count, 32'h6);
      imem_ack = 1'b0; freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h300;
      tick();
      chk("flush_if_valid", {31'b0, if_valid}, 32'h0);
      freeze = 1'b0; branch_taken = 1'b0;

      // Reset while in DISCARD with an ack present
      reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h12;
      tick();
      chk("mid_rst_if_valid", {31'b0, if_valid}, 32'h0);
      chk("mid_rst_if_pc", if_pc, 32'h0);
      chk("mid_rst_if_instr", if_instr, 32'h0);
      chk("mid_rst_count", fetched_count, 32'h0);
      reset = 1'b1; imem_ack = 1'b0;
      #1;
      chk("mid_rst_start_req", {31'b0, imem_req}, 32'h0);
      pc_load = 1'b1; pc_load_val = 32'hFFFF_FFFC;
      tick();
      pc_load = 1'b0;

      // PC wrap
      imem_ack = 1'b1; imem_rdata = 32'h99;
      #1;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_pc_next", pc_next, 32'h0);
      tick();
      imem_ack = 1'b0;
      #1;
      chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_if_instr", if_instr, 32'h99);
      chk("wrap_count", fetched_count, 32'h1);
      chk("wrap_new_addr", imem_addr, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that drives the freeze and next-address inputs of the PC register.
- Issues instruction-memory requests at the current PC using a req/ack handshake, and delivers fetched words to the IF/ID stage register.
- Applies hazard stalls and branch redirects, and drops responses that arrive after a redirect.
- Sits between the PC register, instruction memory, the hazard unit and the EX-stage branch logic.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
STEP, 4, sequential PC increment in bytes
CNT_W, 32, width of the delivered-instruction counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
pc  in  ADDR_W  current PC register value
pc_next  out  ADDR_W  next-address input to the PC register (combinational)
pc_freeze  out  1  freeze input to the PC register (combinational); 0 = PC loads pc_next at this edge
freeze  in  1  hazard stall; IF/ID outputs and PC must hold
branch_taken  in  1  single-cycle redirect pulse from EX
branch_addr  in  ADDR_W  redirect target, valid with branch_taken
imem_req  out  1  fetch request (combinational from state)
imem_addr  out  ADDR_W  fetch address; equals pc
imem_ack  in  1  response valid; meaningful only while imem_req=1
imem_rdata  in  DATA_W  instruction word, valid with imem_ack
if_valid  out  1  IF/ID register valid (registered)
if_pc  out  ADDR_W  PC of the delivered instruction (registered)
if_instr  out  DATA_W  delivered instruction (registered)
fetched_count  out  CNT_W  instructions delivered; saturates at all-ones

Behaviour:
- States: START, FETCH, HOLD, DISCARD. Registers: pend_instr, pend_pc, redir_addr.
- Reset: state=START. if_valid=0, if_pc=0, if_instr=0, pend_*=0, redir_addr=0, fetched_count=0. Reset overrides every other input in that cycle.
- Reset mid-transaction: any outstanding ack is not tracked. Instruction memory shares this reset.
- Default outputs: imem_req=0, pc_freeze=1, pc_next=pc.
- START: outputs at default. Next state is FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc. Address stays stable until ack. Evaluate in priority order:
  1. branch_taken & imem_ack: drop rdata; pc_next=branch_addr, pc_freeze=0; if_valid<=0; stay FETCH.
  2. branch_taken & !imem_ack: redir_addr<=branch_addr; if_valid<=0; go DISCARD. PC stays frozen.
  3. imem_ack & freeze: pend_instr<=rdata, pend_pc<=pc; go HOLD. IF/ID and PC hold.
  4. imem_ack & !freeze: if_instr<=rdata, if_pc<=pc, if_valid<=1; pc_next=pc+STEP, pc_freeze=0; fetched_count++; stay FETCH.
  5. No ack: stay FETCH. IF/ID holds if freeze=1, otherwise if_valid<=0 (bubble).
- Throughput: a zero-wait memory (ack in the request cycle) gives one instruction per cycle.
- HOLD: imem_req=0. Evaluate in priority order:
  1. branch_taken: discard pend; pc_next=branch_addr, pc_freeze=0; if_valid<=0; go FETCH.
  2. !freeze: if_* <= pend_*, if_valid<=1; pc_next=pc+STEP, pc_freeze=0; fetched_count++; go FETCH.
  3. Otherwise stay HOLD.
- DISCARD: imem_req=1 at the unchanged pc. Evaluate in order:
  1. A new branch_taken overwrites redir_addr (newest wins).
  2. On ack: drop rdata; pc_next = (branch_taken ? branch_addr : redir_addr), pc_freeze=0; go FETCH.
  3. if_valid stays 0.
- branch_taken always outranks freeze (flush beats stall).
- PC arithmetic: pc+STEP wraps modulo 2^ADDR_W with no flag.
- imem_ack while imem_req=0 is ignored.

Decomposition:
- Shared pipeline package holds: the state enum (START, FETCH, HOLD, DISCARD), STEP, ADDR_W and DATA_W defaults.
- No sub-module is needed. The saturating counter stays inline.

Test Plan:
- Reset, then zero-wait memory returning 0x11,0x22,0x33 -> START for 1 cycle; if_pc 0,4,8 with matching if_instr on consecutive cycles; fetched_count=3.
- Ack delayed 3 cycles at pc=0x10 -> imem_addr=0x10 and pc_freeze=1 throughout; if_valid=0 for those cycles; on ack pc_next=0x14.
- freeze=1 from before ack at pc=0x20 until 2 cycles after ack -> state HOLD; if_* unchanged; on release if_pc=0x20, next request at 0x24.
- branch_taken to 0x100 one cycle after the request at 0x40, ack 2 cycles later with 0xDEAD -> 0xDEAD never reaches if_instr; next imem_addr=0x100.
- In DISCARD, second branch to 0x200 coinciding with ack -> next fetch at 0x200; branch plus freeze in the same cycle -> flush wins, if_valid=0.
- reset=0 while in DISCARD, and pc=0xFFFFFFFC with ack -> state START, all outputs at reset values; wrapped pc_next=0x0.
